// File: rtl/aDefinitions.sv
// rtl/aDefinitions.sv - shared instruction-format definitions for the decode and execution units
package aDefinitions;

    localparam int INSTRUCTION_WIDTH = 64;
    localparam int OP_LENGTH         = 6;
    localparam int ADDR_WIDTH        = 16;

    // Fixed field positions inside the encoded instruction
    localparam int SRC0_LSB = 0;
    localparam int SRC1_LSB = 16;
    localparam int DEST_LSB = 32;

    // Opcode sits at the top of the instruction word
    function automatic int opLsb(input int instrWidth, input int opLength);
        return instrWidth - opLength;
    endfunction

endpackage

// File: rtl/pipe_ff.sv
// rtl/pipe_ff.sv - enabled pipeline register with optional synchronous clear
module pipe_ff #(
    parameter int WIDTH     = 16,
    parameter bit HAS_RESET = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Clear wins over load only when this field is resettable; otherwise load or hold
    always_ff @(posedge Clock) begin
        if (HAS_RESET && Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/idu_pipestage_regs.sv
// rtl/idu_pipestage_regs.sv - decode pipe-stage register bank splitting the instruction into fields
module idu_pipestage_regs
    import aDefinitions::*;
#(
    parameter int INSTRUCTION_WIDTH = aDefinitions::INSTRUCTION_WIDTH,
    parameter int OP_LENGTH         = aDefinitions::OP_LENGTH,
    parameter int ADDR_WIDTH        = aDefinitions::ADDR_WIDTH
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iLatch,
    input  logic [INSTRUCTION_WIDTH-1:0] iEncodedInstruction,
    output logic [ADDR_WIDTH-1:0]        oSourceAddress0,
    output logic [ADDR_WIDTH-1:0]        oSourceAddress1,
    output logic [ADDR_WIDTH-1:0]        oDestination,
    output logic [OP_LENGTH-1:0]         oOperation
);

    localparam int OP_LSB   = opLsb(INSTRUCTION_WIDTH, OP_LENGTH);
    localparam int GAP_LSB  = DEST_LSB + ADDR_WIDTH;
    localparam int GAP_MSB  = OP_LSB - 1;

    // Bits between the destination and the opcode carry nothing for this stage
    logic unusedGapBits;
    assign unusedGapBits = ^iEncodedInstruction[GAP_MSB:GAP_LSB];

    // Source addresses are cleared by Reset so downstream operand fetch starts from a known slot
    pipe_ff #(.WIDTH(ADDR_WIDTH), .HAS_RESET(1'b1)) source0Reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (iLatch),
        .D      (iEncodedInstruction[SRC0_LSB +: ADDR_WIDTH]),
        .Q      (oSourceAddress0)
    );

    pipe_ff #(.WIDTH(ADDR_WIDTH), .HAS_RESET(1'b1)) source1Reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (iLatch),
        .D      (iEncodedInstruction[SRC1_LSB +: ADDR_WIDTH]),
        .Q      (oSourceAddress1)
    );

    // Destination and opcode are plain datapath registers: Reset never touches them
    pipe_ff #(.WIDTH(ADDR_WIDTH), .HAS_RESET(1'b0)) destinationReg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (iLatch),
        .D      (iEncodedInstruction[DEST_LSB +: ADDR_WIDTH]),
        .Q      (oDestination)
    );

    pipe_ff #(.WIDTH(OP_LENGTH), .HAS_RESET(1'b0)) operationReg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (iLatch),
        .D      (iEncodedInstruction[OP_LSB +: OP_LENGTH]),
        .Q      (oOperation)
    );

endmodule

// File: tb/tb_idu_pipestage_regs.sv
// tb/tb_idu_pipestage_regs.sv - self-checking bench for the decode pipe-stage register bank
module tb_idu_pipestage_regs;

    logic        Clock;
    logic        Reset;
    logic        iLatch;
    logic [63:0] iEncodedInstruction;
    logic [15:0] oSourceAddress0;
    logic [15:0] oSourceAddress1;
    logic [15:0] oDestination;
    logic [5:0]  oOperation;

    int compared;
    int mismatched;

    // Reference state: what each output must hold, plus whether it is defined yet
    logic [15:0] mSrc0, mSrc1, mDest;
    logic [5:0]  mOp;
    bit          mSrcKnown;
    bit          mDestKnown;

    idu_pipestage_regs dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .iLatch              (iLatch),
        .iEncodedInstruction (iEncodedInstruction),
        .oSourceAddress0     (oSourceAddress0),
        .oSourceAddress1     (oSourceAddress1),
        .oDestination        (oDestination),
        .oOperation          (oOperation)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model: sources clear on reset, otherwise every field copies its slice on a latch
    always @(posedge Clock) begin
        if (Reset) begin
            mSrc0     = 16'd0;
            mSrc1     = 16'd0;
            mSrcKnown = 1'b1;
        end else if (iLatch) begin
            mSrc0     = 16'(iEncodedInstruction % 64'h1_0000);
            mSrc1     = 16'((iEncodedInstruction / 64'h1_0000) % 64'h1_0000);
            mSrcKnown = 1'b1;
        end
        if (iLatch) begin
            mDest      = 16'((iEncodedInstruction / 64'h1_0000_0000) % 64'h1_0000);
            mOp        = 6'(iEncodedInstruction / (64'd1 << 58));
            mDestKnown = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge: compare all defined outputs against the model
    always @(negedge Clock) begin
        if (mSrcKnown) begin
            check("model_src0", {48'd0, oSourceAddress0}, {48'd0, mSrc0});
            check("model_src1", {48'd0, oSourceAddress1}, {48'd0, mSrc1});
        end
        if (mDestKnown) begin
            check("model_dest", {48'd0, oDestination}, {48'd0, mDest});
            check("model_op",   {58'd0, oOperation},   {58'd0, mOp});
        end
    end

    task automatic step(input logic rst, input logic latch, input logic [63:0] instr);
        @(negedge Clock);
        Reset               = rst;
        iLatch              = latch;
        iEncodedInstruction = instr;
        @(posedge Clock);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] d, input logic [5:0] op);
        check({tag, "_src0"}, {48'd0, oSourceAddress0}, {48'd0, s0});
        check({tag, "_src1"}, {48'd0, oSourceAddress1}, {48'd0, s1});
        check({tag, "_dest"}, {48'd0, oDestination},    {48'd0, d});
        check({tag, "_op"},   {58'd0, oOperation},      {58'd0, op});
    endtask

    logic [63:0] instrA, instrB, randInstr;

    initial begin
        compared   = 0;
        mismatched = 0;
        mSrcKnown  = 1'b0;
        mDestKnown = 1'b0;
        Reset      = 1'b1;
        iLatch     = 1'b0;
        iEncodedInstruction = 64'd0;

        // Reset for one edge clears the source addresses
        step(1'b1, 1'b0, 64'd0);
        check("reset_src0", {48'd0, oSourceAddress0}, 64'd0);
        check("reset_src1", {48'd0, oSourceAddress1}, 64'd0);
        step(1'b0, 1'b0, 64'd0);

        // Single load, visible one cycle later
        step(1'b0, 1'b1, {6'h05, 10'h3FF, 16'h00A1, 16'h0003, 16'h0007});
        checkAll("load", 16'h0007, 16'h0003, 16'h00A1, 6'h05);

        // Hold through five edges with all-ones on the input
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '1);
        checkAll("hold", 16'h0007, 16'h0003, 16'h00A1, 6'h05);

        // Selective reset keeps destination and opcode
        step(1'b1, 1'b0, '1);
        checkAll("selreset", 16'h0000, 16'h0000, 16'h00A1, 6'h05);

        // Reset and load together: sources cleared, others load
        step(1'b1, 1'b1, {6'h3F, 10'h000, 16'hFFFF, 16'h5678, 16'h1234});
        checkAll("rstload", 16'h0000, 16'h0000, 16'hFFFF, 6'h3F);

        // Back-to-back loads track each instruction one cycle later
        instrA = {6'h2A, 10'h155, 16'hBEEF, 16'hCAFE, 16'h0101};
        instrB = {6'h11, 10'h2AA, 16'h1357, 16'h2468, 16'hFFFF};
        step(1'b0, 1'b1, instrA);
        checkAll("b2b_a", 16'h0101, 16'hCAFE, 16'hBEEF, 6'h2A);
        step(1'b0, 1'b1, instrB);
        checkAll("b2b_b", 16'hFFFF, 16'h2468, 16'h1357, 6'h11);
        step(1'b0, 1'b0, 64'd0);
        checkAll("b2b_hold", 16'hFFFF, 16'h2468, 16'h1357, 6'h11);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            randInstr = {$urandom, $urandom};
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1), randInstr);
        end

        @(negedge Clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/idu_pipestage_regs.md
IDU_PIPESTAGE_REGS -- requirements
Module: idu_pipestage_regs

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 64, meaning encoded instruction width in bits.
REQ-002 SHALL have parameter OP_LENGTH, default 6, meaning opcode field width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning address field width.
REQ-004 Clock  input  1  single rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 iLatch  input  1  load enable; captures the instruction fields on the rising Clock edge.
REQ-007 iEncodedInstruction  input  INSTRUCTION_WIDTH  encoded instruction from fetch.
REQ-008 oSourceAddress0  output  ADDR_WIDTH  registered field [15:0].
REQ-009 oSourceAddress1  output  ADDR_WIDTH  registered field [31:16].
REQ-010 oDestination  output  ADDR_WIDTH  registered field [47:32].
REQ-011 oOperation  output  OP_LENGTH  registered opcode field [INSTRUCTION_WIDTH-1 : INSTRUCTION_WIDTH-OP_LENGTH].
REQ-012 One clock; reset is synchronous and active-high, ports named Clock and Reset.

Function
REQ-013 On a rising Clock edge with Reset=0 and iLatch=1, all four outputs SHALL take their fields from iEncodedInstruction. Latency is 1 cycle.
REQ-014 On a rising Clock edge with Reset=0 and iLatch=0, all outputs SHALL hold their values.
REQ-015 Outputs SHALL change only on rising Clock edges. There are no combinational paths from inputs to outputs.
REQ-016 Field slicing SHALL be fixed bit positions with no sign extension or arithmetic. Bits between 47 and the opcode field SHALL be ignored.
REQ-017 Reset=1 and iLatch=1 on the same edge: reset SHALL win for the resettable fields (REQ-019). The non-resettable fields (REQ-020) SHALL load normally.
REQ-018 No state machine. The block is a pure pipe-stage register bank.

Reset
REQ-019 On a rising edge with Reset=1, oSourceAddress0 and oSourceAddress1 SHALL become 0 regardless of iLatch.
REQ-020 oDestination and oOperation SHALL NOT be reset. Their value is unknown until the first load, and Reset SHALL not alter a loaded value.
REQ-021 Reset asserted mid-operation SHALL take effect on the next rising edge only, with no asynchronous clear.

Structure
REQ-022 INSTRUCTION_WIDTH, OP_LENGTH, ADDR_WIDTH and the field bit positions SHALL come from the shared definitions package (aDefinitions) used by the execution unit.
REQ-023 A single sub-module pipe_ff SHALL be used for every field. It has parameters WIDTH and HAS_RESET, and ports Clock, Reset, Enable, D, Q.
REQ-024 Instances SHALL be:
- two with HAS_RESET=1 (source addresses);
- two with HAS_RESET=0 (destination, opcode).

Verification
REQ-025 Reset: Reset=1 for 1 edge, then Reset=0 -> oSourceAddress0=0 and oSourceAddress1=0 from the next edge.
REQ-026 Load: iEncodedInstruction with opcode 6'h05, bits [47:32]=16'h00A1, [31:16]=16'h0003, [15:0]=16'h0007, and iLatch=1 for one edge -> one cycle later oOperation=5, oDestination=0x00A1, oSourceAddress1=3, oSourceAddress0=7.
REQ-027 Hold: change iEncodedInstruction to all-ones with iLatch=0 for 5 edges -> all outputs unchanged from REQ-026.
REQ-028 Selective reset: after REQ-026, Reset=1 with iLatch=0 -> source addresses become 0; oDestination=0x00A1 and oOperation=5 are retained.
REQ-029 Simultaneous reset and load: Reset=1, iLatch=1, opcode 6'h3F, destination 16'hFFFF, sources 16'h1234/16'h5678 -> source addresses 0, oDestination=0xFFFF, oOperation=0x3F.
REQ-030 Back-to-back loads: iLatch=1 on consecutive edges with different instructions -> outputs track each instruction exactly one cycle later with no dropped value.
